// File: rtl/sram_access_sequencer_if.sv
// Request/response handshake between a user-side requester and the SRAM access sequencer.
interface sram_access_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_access_sequencer.sv
// Turns one SRAM read/write request into timed phase codes for the 3-to-8 control decoder.
// Optional SRAM_SEQ_BACK2BACK_EN: also accept a new request in DONE, skipping the IDLE cycle.
module sram_access_sequencer #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int PRECH_CYC = 2,
  parameter int SENSE_CYC = 2,
  parameter int WRITE_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_access_sequencer_if.slave req_if,
  output logic [2:0]            ctrl_addr_o,
  output logic                  ctrl_en_o,
  output logic [ADDR_W-1:0]     row_addr_o,
  output logic [DATA_W-1:0]     wdata_o,
  input  logic [DATA_W-1:0]     sense_data_i,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRECH, S_ADDR, S_WL, S_WRITE, S_SENSE, S_LATCH, S_DONE
  } state_e;

  localparam logic [2:0] PH_PRECH = 3'd0;
  localparam logic [2:0] PH_ADDR  = 3'd1;
  localparam logic [2:0] PH_WL    = 3'd2;
  localparam logic [2:0] PH_WRITE = 3'd3;
  localparam logic [2:0] PH_SENSE = 3'd4;
  localparam logic [2:0] PH_LATCH = 3'd5;

  // Counter holds remaining cycles minus one, so a phase exits when it reads zero.
  localparam logic [3:0] PRECH_LD = 4'(PRECH_CYC - 1);
  localparam logic [3:0] SENSE_LD = 4'(SENSE_CYC - 1);
  localparam logic [3:0] WRITE_LD = 4'(WRITE_CYC - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] row_addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              req_ready;
  logic              accept;

  always_comb begin
    req_ready = (state_q == S_IDLE);
`ifdef SRAM_SEQ_BACK2BACK_EN
    req_ready = req_ready || (state_q == S_DONE);
`endif
  end

  assign accept = req_if.req_valid && req_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_PRECH;
        cnt_d   = PRECH_LD;
      end
      S_PRECH: if (cnt_q == '0) begin
        state_d = S_ADDR;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      S_ADDR: if (we_q) begin
        state_d = S_WRITE;
        cnt_d   = WRITE_LD;
      end else begin
        state_d = S_WL;
        cnt_d   = '0;
      end
      S_WRITE: if (cnt_q == '0) state_d = S_DONE;
               else             cnt_d   = cnt_q - 4'd1;
      S_WL: begin
        state_d = S_SENSE;
        cnt_d   = SENSE_LD;
      end
      S_SENSE: if (cnt_q == '0) begin
        state_d = S_LATCH;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      S_LATCH: state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
`ifdef SRAM_SEQ_BACK2BACK_EN
        if (accept) begin
          state_d = S_PRECH;
          cnt_d   = PRECH_LD;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      row_addr_q  <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q       <= req_if.req_we;
        row_addr_q <= req_if.req_addr;
        wdata_q    <= req_if.req_wdata;
      end
      if (state_q == S_LATCH) rsp_rdata_q <= sense_data_i;
    end
  end

  // Control outputs decode from state alone, keeping req_* off the ctrl_* timing path.
  always_comb begin
    ctrl_en_o   = 1'b1;
    ctrl_addr_o = PH_PRECH;
    unique case (state_q)
      S_PRECH: ctrl_addr_o = PH_PRECH;
      S_ADDR:  ctrl_addr_o = PH_ADDR;
      S_WL:    ctrl_addr_o = PH_WL;
      S_WRITE: ctrl_addr_o = PH_WRITE;
      S_SENSE: ctrl_addr_o = PH_SENSE;
      S_LATCH: ctrl_addr_o = PH_LATCH;
      default: ctrl_en_o   = 1'b0;
    endcase
  end

  assign busy_o           = (state_q != S_IDLE);
  assign row_addr_o       = row_addr_q;
  assign wdata_o          = wdata_q;
  assign req_if.req_ready = req_ready;
  assign req_if.rsp_valid = (state_q == S_DONE);
  assign req_if.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sram_access_sequencer.sv
// Directed self-checking bench for sram_access_sequencer; outputs sampled on the falling edge.
module tb_sram_access_sequencer;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [2:0]        ctrl_addr;
  logic              ctrl_en;
  logic [ADDR_W-1:0] row_addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] sense_data = '0;
  logic              busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  sram_access_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) req_if ();

  sram_access_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .PRECH_CYC(2), .SENSE_CYC(2), .WRITE_CYC(1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_if       (req_if),
    .ctrl_addr_o  (ctrl_addr),
    .ctrl_en_o    (ctrl_en),
    .row_addr_o   (row_addr),
    .wdata_o      (wdata),
    .sense_data_i (sense_data),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_req(input logic valid, input logic we,
                           input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
    req_if.req_valid = valid;
    req_if.req_we    = we;
    req_if.req_addr  = addr;
    req_if.req_wdata = data;
  endtask

  logic [2:0] rd_seq [7];
  logic [2:0] wr_seq [4];
  int         rsp_seen;
  int         first_rsp;
  int         second_rsp;
  logic       en_after_done;
  logic       found;

  initial begin
    rd_seq = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd4, 3'd4, 3'd5};
    wr_seq = '{3'd0, 3'd0, 3'd1, 3'd3};
    drive_req(1'b0, 1'b0, '0, '0);

    // Reset values
    step(); step();
    check("rst_ctrl_en",   32'(ctrl_en), 32'd0);
    check("rst_ctrl_addr", 32'(ctrl_addr), 32'd0);
    check("rst_ready",     32'(req_if.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(req_if.rsp_valid), 32'd0);
    check("rst_rdata",     32'(req_if.rsp_rdata), 32'd0);
    check("rst_row_wdata", 32'({row_addr, wdata}), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_hold", 32'({busy, ctrl_en, req_if.rsp_valid, req_if.req_ready}), 32'b0001);
    end

    // Write A <= 5C: phases 0,0,1,3 then one response pulse after edge 4
    drive_req(1'b1, 1'b1, 4'hA, 8'h5C);
    step();
    drive_req(1'b0, 1'b0, 4'h0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wr_phase%0d", i), 32'({ctrl_en, ctrl_addr}), 32'({1'b1, wr_seq[i]}));
      if (i == 0) begin
        check("wr_row_addr", 32'(row_addr), 32'hA);
        check("wr_wdata",    32'(wdata), 32'h5C);
        check("wr_ready_busy", 32'({req_if.req_ready, busy}), 32'b01);
      end
      if (i < 3) step();
    end
    step();
    check("wr_rsp_valid", 32'({req_if.rsp_valid, ctrl_en}), 32'b10);
    check("wr_rdata_kept", 32'(req_if.rsp_rdata), 32'h00);
    step();
    check("wr_rsp_drop", 32'({req_if.rsp_valid, req_if.req_ready, busy}), 32'b010);
    check("wr_row_kept", 32'({row_addr, wdata}), 32'hA5C);

    // Read row 3 with sense data C3
    sense_data = 8'hC3;
    drive_req(1'b1, 1'b0, 4'h3, 8'hFF);
    step();
    drive_req(1'b0, 1'b0, 4'h0, 8'h00);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("rd_phase%0d", i), 32'({ctrl_en, ctrl_addr}), 32'({1'b1, rd_seq[i]}));
      check($sformatf("rd_no_rsp%0d", i), 32'(req_if.rsp_valid), 32'd0);
      step();
    end
    check("rd_rsp_valid", 32'({req_if.rsp_valid, ctrl_en}), 32'b10);
    check("rd_rdata", 32'(req_if.rsp_rdata), 32'hC3);
    check("rd_wdata_kept", 32'(wdata), 32'hFF);
    sense_data = 8'h00;
    step(); step();
    check("rd_rdata_hold", 32'(req_if.rsp_rdata), 32'hC3);

    // Busy ignore: a write to F is held during a read of row 3 and must wait
    sense_data = 8'h5A;
    drive_req(1'b1, 1'b0, 4'h3, 8'h00);
    step();
    drive_req(1'b1, 1'b1, 4'hF, 8'h11);
    rsp_seen = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) req_if.req_addr = 4'h7;
      check($sformatf("busy_phase%0d", i), 32'({ctrl_en, ctrl_addr}), 32'({1'b1, rd_seq[i]}));
      check($sformatf("busy_row%0d", i), 32'(row_addr), 32'h3);
      if (req_if.rsp_valid) rsp_seen++;
      step();
    end
    if (req_if.rsp_valid) rsp_seen++;
    check("busy_rd_rdata", 32'(req_if.rsp_rdata), 32'h5A);
    step();
`ifdef SRAM_SEQ_BACK2BACK_EN
    check("busy_wr_accept", 32'({ctrl_en, ctrl_addr, row_addr}), 32'({1'b1, 3'd0, 4'h7}));
`else
    check("busy_wr_wait", 32'({ctrl_en, req_if.req_ready, row_addr}), 32'({1'b0, 1'b1, 4'h3}));
    if (req_if.rsp_valid) rsp_seen++;
    step();
    check("busy_wr_accept", 32'({ctrl_en, ctrl_addr, row_addr}), 32'({1'b1, 3'd0, 4'h7}));
`endif
    check("busy_one_rsp", 32'(rsp_seen), 32'd1);
    drive_req(1'b0, 1'b0, 4'h0, 8'h00);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = req_if.rsp_valid;
    end
    check("busy_wr_done", 32'(found), 32'd1);
    check("busy_wr_rdata", 32'(req_if.rsp_rdata), 32'h5A);
    step();

    // Asynchronous reset while in SENSE
    drive_req(1'b1, 1'b0, 4'h6, 8'h00);
    step();
    drive_req(1'b0, 1'b0, 4'h0, 8'h00);
    step(); step(); step(); step();
    check("ar_in_sense", 32'({ctrl_en, ctrl_addr}), 32'({1'b1, 3'd4}));
    #2 rst_n = 1'b0;
    #1;
    check("ar_en_drop", 32'({ctrl_en, ctrl_addr, busy}), 32'd0);
    check("ar_ready", 32'(req_if.req_ready), 32'd1);
    check("ar_row_clear", 32'(row_addr), 32'd0);
    #1 rst_n = 1'b1;
    rsp_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (req_if.rsp_valid || ctrl_en) rsp_seen++;
    end
    check("ar_no_rsp", 32'(rsp_seen), 32'd0);

    // Back-to-back reads with req_valid held high
    sense_data = 8'h77;
    drive_req(1'b1, 1'b0, 4'h5, 8'h00);
    first_rsp     = -1;
    second_rsp    = -1;
    en_after_done = 1'bx;
    for (int i = 0; i < 40 && second_rsp < 0; i++) begin
      step();
      if (first_rsp >= 0 && i == first_rsp + 1) en_after_done = ctrl_en;
      if (req_if.rsp_valid) begin
        if (first_rsp < 0) first_rsp = i;
        else               second_rsp = i;
      end
    end
    drive_req(1'b0, 1'b0, 4'h0, 8'h00);
    check("b2b_first_at_7", 32'(first_rsp), 32'd7);
`ifdef SRAM_SEQ_BACK2BACK_EN
    check("b2b_gap", 32'(second_rsp - first_rsp), 32'd8);
    check("b2b_prech_after_done", 32'(en_after_done), 32'd1);
`else
    check("b2b_gap", 32'(second_rsp - first_rsp), 32'd9);
    check("b2b_idle_after_done", 32'(en_after_done), 32'd0);
`endif
    check("b2b_rdata", 32'(req_if.rsp_rdata), 32'h77);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = !busy;
    end
    check("b2b_drain", 32'(found), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
